// File: rtl/joypad_pkg.sv
// joypad_pkg: shared constants for the joypad conditioning slice.
// Button indices match the ball_absolute direction inputs.
package joypad_pkg;

    localparam int N_BUTTONS = 4;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    // 10 ms at a 25 MHz pixel clock
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
    localparam int SYNC_STAGES_DEFAULT     = 2;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: synchronizer, debounce counter and rising-edge detect
// for one raw button input.
module debounce_bit
    import joypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_stable,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   stable_dly_q, stable_dly_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Next state: shift the synchronizer, run the debounce counter.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], i_btn};
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        if (sync == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; everything clears on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
        end
    end

    assign o_stable = stable_q;
    assign o_rise   = stable_q & ~stable_dly_q;

endmodule

// File: rtl/joypad_conditioner.sv
// joypad_conditioner: debounces four buttons and publishes press pulses,
// frame-latched levels and per-frame press flags at each vsync rise.
module joypad_conditioner
    import joypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_BUTTONS-1:0] i_btn,
    input  logic                 i_vsync,
    output logic [N_BUTTONS-1:0] o_held,
    output logic [N_BUTTONS-1:0] o_pressed,
    output logic [N_BUTTONS-1:0] o_frame_pressed,
    output logic                 o_frame_strobe
);

    logic [N_BUTTONS-1:0] stable, rise;
    logic                 vsync_edge;

    logic [N_BUTTONS-1:0] held_q, held_d;
    logic [N_BUTTONS-1:0] pressed_q, pressed_d;
    logic [N_BUTTONS-1:0] frame_pressed_q, frame_pressed_d;
    logic [N_BUTTONS-1:0] acc_q, acc_d;
    logic                 vsync_prev_q, vsync_prev_d;
    logic                 strobe_q, strobe_d;

    for (genvar k = 0; k < N_BUTTONS; k++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_btn   (i_btn[k]),
            .o_stable(stable[k]),
            .o_rise  (rise[k])
        );
    end

    assign vsync_edge = i_vsync & ~vsync_prev_q;

    // Frame publish at vsync rise; a rise in that same cycle lands in
    // the published frame and is not carried forward.
    always_comb begin
        held_d          = held_q;
        frame_pressed_d = frame_pressed_q;
        acc_d           = acc_q | rise;
        pressed_d       = rise;
        vsync_prev_d    = i_vsync;
        strobe_d        = vsync_edge;
        if (vsync_edge) begin
            held_d          = stable;
            frame_pressed_d = acc_q | rise;
            acc_d           = '0;
        end
    end

    // Output and accumulator registers; vsync_prev starts high so a
    // vsync already high at release is not taken as an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            held_q          <= '0;
            pressed_q       <= '0;
            frame_pressed_q <= '0;
            acc_q           <= '0;
            vsync_prev_q    <= 1'b1;
            strobe_q        <= 1'b0;
        end else begin
            held_q          <= held_d;
            pressed_q       <= pressed_d;
            frame_pressed_q <= frame_pressed_d;
            acc_q           <= acc_d;
            vsync_prev_q    <= vsync_prev_d;
            strobe_q        <= strobe_d;
        end
    end

    assign o_held          = held_q;
    assign o_pressed       = pressed_q;
    assign o_frame_pressed = frame_pressed_q;
    assign o_frame_strobe  = strobe_q;

endmodule

// File: tb/tb_joypad_conditioner.sv
// tb_joypad_conditioner: directed scenarios against a window-based
// behavioural model, plus hand-computed literal expectations.
module tb_joypad_conditioner;
    import joypad_pkg::*;

    localparam int DB = 4;
    localparam int SS = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       vsync;
    logic [3:0] held, pressed, fpress;
    logic       strobe;

    int n_cmp = 0;
    int n_bad = 0;
    int pc2 = 0;
    int sc  = 0;

    joypad_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .SYNC_STAGES    (SS)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_btn          (btn),
        .i_vsync        (vsync),
        .o_held         (held),
        .o_pressed      (pressed),
        .o_frame_pressed(fpress),
        .o_frame_strobe (strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stable level flips once the last DB
    // synchronized samples all disagree with it.
    logic [3:0] m_dl  [SS];
    logic [3:0] m_win [DB-1];
    logic [3:0] m_stab, m_stab_d, m_acc, m_held, m_fp, m_pr;
    logic       m_vprev, m_strobe;
    logic [3:0] s_now, m_rise, m_flip;
    logic       m_ve;

    assign s_now  = m_dl[SS-1];
    assign m_rise = m_stab & ~m_stab_d;
    assign m_ve   = vsync & ~m_vprev;

    always_comb begin
        m_flip = s_now ^ m_stab;
        for (int i = 0; i < DB - 1; i++)
            m_flip = m_flip & (m_win[i] ^ m_stab);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) m_dl[i] <= '0;
            for (int i = 0; i < DB - 1; i++) m_win[i] <= '0;
            m_stab   <= '0;
            m_stab_d <= '0;
            m_acc    <= '0;
            m_held   <= '0;
            m_fp     <= '0;
            m_pr     <= '0;
            m_vprev  <= 1'b1;
            m_strobe <= 1'b0;
        end else begin
            m_dl[0] <= btn;
            for (int i = 1; i < SS; i++) m_dl[i] <= m_dl[i-1];
            m_win[0] <= s_now;
            for (int i = 1; i < DB - 1; i++) m_win[i] <= m_win[i-1];
            m_stab   <= m_stab ^ m_flip;
            m_stab_d <= m_stab;
            m_pr     <= m_rise;
            m_vprev  <= vsync;
            m_strobe <= m_ve;
            if (m_ve) begin
                m_held <= m_stab;
                m_fp   <= m_acc | m_rise;
                m_acc  <= '0;
            end else begin
                m_acc <= m_acc | m_rise;
            end
        end
    end

    // Every-cycle comparison against the model, away from the edge.
    always @(negedge clk) begin
        check("held", held, m_held);
        check("pressed", pressed, m_pr);
        check("frame_pressed", fpress, m_fp);
        check("strobe", strobe, m_strobe);
    end

    always @(negedge clk) begin
        if (pressed[BTN_LEFT]) pc2 <= pc2 + 1;
        if (strobe) sc <= sc + 1;
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        @(posedge clk);
        #2;
        vsync = 1'b0;
        @(negedge clk);
    endtask

    int base;

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0000;
        vsync = 1'b0;
        step(3);
        @(negedge clk);
        check("rst_held", held, 0);
        check("rst_pressed", pressed, 0);
        check("rst_fp", fpress, 0);
        check("rst_strobe", strobe, 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // 1: single press on up
        btn = 4'b0001;
        step(6);
        @(negedge clk);
        check("s1_pr_e6", pressed, 4'b0000);
        step(1);
        @(negedge clk);
        check("s1_pr_e7", pressed, 4'b0001);
        check("s1_held_e7", held, 4'b0000);
        step(1);
        @(negedge clk);
        check("s1_pr_e8", pressed, 4'b0000);
        vsync_pulse();
        check("s1_held_v", held, 4'b0001);
        check("s1_fp_v", fpress, 4'b0001);
        check("s1_strobe_v", strobe, 1);
        step(1);
        @(negedge clk);
        check("s1_strobe_off", strobe, 0);
        btn = 4'b0000;
        step(10);

        // 2: bounce on left, then a clean 4-cycle stretch
        base = pc2;
        btn = 4'b0100; step(3);
        btn = 4'b0000; step(1);
        btn = 4'b0100; step(3);
        btn = 4'b0000; step(8);
        check("s2_bounce_pulses", pc2 - base, 0);
        btn = 4'b0100; step(4);
        btn = 4'b0000; step(10);
        check("s2_clean_pulses", pc2 - base, 1);

        // 3: press and release within a frame
        vsync_pulse();
        check("s3_fp_prev", fpress, 4'b0100);
        check("s3_held_prev", held, 4'b0000);
        btn = 4'b0001; step(8);
        btn = 4'b0000; step(10);
        vsync_pulse();
        check("s3_fp", fpress, 4'b0001);
        check("s3_held", held, 4'b0000);
        check("s3_strobe", strobe, 1);
        step(1);
        @(negedge clk);
        check("s3_strobe_off", strobe, 0);
        step(5);
        vsync_pulse();
        check("s3_fp_idle", fpress, 4'b0000);

        // 4: right rise coincides with the vsync edge
        step(1);
        btn = 4'b1000;
        step(6);
        vsync = 1'b1;
        step(1);
        vsync = 1'b0;
        @(negedge clk);
        check("s4_fp", fpress, 4'b1000);
        check("s4_pr", pressed, 4'b1000);
        check("s4_held", held, 4'b1000);
        check("s4_strobe", strobe, 1);
        step(2);
        btn = 4'b0000;
        step(10);
        vsync_pulse();
        check("s4_fp_next", fpress, 4'b0000);
        check("s4_held_next", held, 4'b0000);

        // 5: reset mid-count with accumulated presses
        step(1);
        btn = 4'b0001; step(8);
        vsync_pulse();
        check("s5_held_pre", held, 4'b0001);
        step(1);
        btn = 4'b0011; step(8);
        btn = 4'b1111; step(3);
        rst_n = 1'b0;
        #1;
        check("s5_rst_held", held, 0);
        check("s5_rst_pr", pressed, 0);
        check("s5_rst_fp", fpress, 0);
        check("s5_rst_strobe", strobe, 0);
        step(2);
        rst_n = 1'b1;
        step(6);
        @(negedge clk);
        check("s5_pr_e6", pressed, 4'b0000);
        step(1);
        @(negedge clk);
        check("s5_pr_e7", pressed, 4'b1111);
        step(3);
        vsync_pulse();
        check("s5_fp", fpress, 4'b1111);
        check("s5_held", held, 4'b1111);
        step(1);
        btn = 4'b0000;
        step(10);
        vsync_pulse();
        check("s5_fp_next", fpress, 4'b0000);
        check("s5_held_next", held, 4'b0000);

        // 6: vsync high across reset release
        step(1);
        rst_n = 1'b0;
        vsync = 1'b1;
        step(2);
        base = sc;
        rst_n = 1'b1;
        step(100);
        check("s6_no_strobe", sc - base, 0);
        vsync = 1'b0; step(5);
        vsync = 1'b1; step(3);
        check("s6_one_strobe", sc - base, 1);
        vsync = 1'b0; step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
